// File: rtl/alu_adder_data_memory.sv
// Combinational 32/64-bit ALU, a standalone 32-bit adder and a word-addressed
// data memory with single- and double-word writes and a two-word read port.
module alu_adder_data_memory #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [31:0] alu_a_hi,
    input  logic [31:0] alu_b_hi,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_out,
    output logic [63:0] alu_out64,
    output logic        zf,
    input  logic [31:0] add_a,
    input  logic [31:0] add_b,
    output logic [31:0] add_sum,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [63:0] mem_wdata64,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_write64,
    output logic [31:0] mem_rdata,
    output logic [31:0] mem_rdata_next
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_ADD64 = 4'd14;
    localparam logic [3:0] OP_SLTU  = 4'd15;

    // ------------------------------------------------------------------
    // Adder
    // ------------------------------------------------------------------
    assign add_sum = add_a + add_b;

    // ------------------------------------------------------------------
    // ALU datapath pieces
    // ------------------------------------------------------------------
    logic [4:0]  shamt;
    logic [31:0] sra_res;
    logic        slt_res;
    logic        sltu_res;
    logic [63:0] add64_res;

    assign shamt     = alu_b[4:0];
    assign sra_res   = $signed(alu_a) >>> shamt;
    assign slt_res   = $signed(alu_a) < $signed(alu_b);
    assign sltu_res  = alu_a < alu_b;
    assign add64_res = {alu_a_hi, alu_a} + {alu_b_hi, alu_b};

    // One 64x64 multiplier serves both MULT and MULTU by choosing the extension.
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_res;

    assign mul_signed = (alu_op == OP_MULT);
    assign mul_a      = {{32{mul_signed & alu_a[31]}}, alu_a};
    assign mul_b      = {{32{mul_signed & alu_b[31]}}, alu_b};
    assign mul_res    = mul_a * mul_b;

    // Signed division runs on magnitudes through the unsigned divider, then the
    // quotient takes the XOR of the signs and the remainder the dividend's sign.
    logic        div_signed;
    logic        div_by_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] div_d_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    assign div_signed  = (alu_op == OP_DIV);
    assign div_by_zero = (alu_b == 32'h0);
    assign a_mag       = alu_a[31] ? (32'h0 - alu_a) : alu_a;
    assign b_mag       = alu_b[31] ? (32'h0 - alu_b) : alu_b;
    assign div_n       = div_signed ? a_mag : alu_a;
    assign div_d       = div_signed ? b_mag : alu_b;
    assign div_d_safe  = div_by_zero ? 32'd1 : div_d;
    assign uq          = div_n / div_d_safe;
    assign ur          = div_n % div_d_safe;

    always_comb begin
        quot = uq;
        rem  = ur;
        if (div_by_zero) begin
            quot = 32'hFFFF_FFFF;
            rem  = alu_a;
        end else if (div_signed) begin
            quot = (alu_a[31] ^ alu_b[31]) ? (32'h0 - uq) : uq;
            rem  = alu_a[31] ? (32'h0 - ur) : ur;
        end
    end

    // ------------------------------------------------------------------
    // ALU result select
    // ------------------------------------------------------------------
    logic [63:0] res64;

    always_comb begin
        res64 = 64'h0;
        case (alu_op)
            OP_AND:   res64 = {32'h0, alu_a & alu_b};
            OP_OR:    res64 = {32'h0, alu_a | alu_b};
            OP_ADD:   res64 = {32'h0, alu_a + alu_b};
            OP_XOR:   res64 = {32'h0, alu_a ^ alu_b};
            OP_NOR:   res64 = {32'h0, ~(alu_a | alu_b)};
            OP_SLL:   res64 = {32'h0, alu_a << shamt};
            OP_SUB:   res64 = {32'h0, alu_a - alu_b};
            OP_SLT:   res64 = {63'h0, slt_res};
            OP_SRL:   res64 = {32'h0, alu_a >> shamt};
            OP_SRA:   res64 = {32'h0, sra_res};
            OP_MULT:  res64 = mul_res;
            OP_MULTU: res64 = mul_res;
            OP_DIV:   res64 = {rem, quot};
            OP_DIVU:  res64 = {rem, quot};
            OP_ADD64: res64 = add64_res;
            OP_SLTU:  res64 = {63'h0, sltu_res};
            default:  res64 = 64'h0;
        endcase
    end

    assign alu_out64 = res64;
    assign alu_out   = res64[31:0];
    assign zf        = (res64[31:0] == 32'h0);

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic [AW-1:0] word_next;
    logic          unused_addr_bits;

    // Index arithmetic is AW bits wide, so W+1 wraps to 0 at the last word.
    assign word_idx         = mem_addr[AW+1:2];
    assign word_next        = word_idx + {{(AW-1){1'b0}}, 1'b1};
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_write64) begin
            mem[word_idx]  <= mem_wdata64[63:32];
            mem[word_next] <= mem_wdata64[31:0];
        end else if (mem_write) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    assign mem_rdata      = mem_read ? mem[word_idx]  : 32'h0;
    assign mem_rdata_next = mem_read ? mem[word_next] : 32'h0;

endmodule

// File: tb/tb_alu_adder_data_memory.sv
// Bench for alu_adder_data_memory: random stimulus checked every cycle against a
// plain-arithmetic model, plus literal scenario checks.
module tb_alu_adder_data_memory;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_a, alu_b, alu_a_hi, alu_b_hi;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic [63:0] alu_out64;
    logic        zf;
    logic [31:0] add_a, add_b, add_sum;
    logic [31:0] mem_addr, mem_wdata;
    logic [63:0] mem_wdata64;
    logic        mem_read, mem_write, mem_write64;
    logic [31:0] mem_rdata, mem_rdata_next;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 1'b0;

    logic [31:0] model_mem [MEM_WORDS];

    alu_adder_data_memory #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_a_hi       (alu_a_hi),
        .alu_b_hi       (alu_b_hi),
        .alu_op         (alu_op),
        .alu_out        (alu_out),
        .alu_out64      (alu_out64),
        .zf             (zf),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_sum        (add_sum),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wdata64    (mem_wdata64),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write64    (mem_write64),
        .mem_rdata      (mem_rdata),
        .mem_rdata_next (mem_rdata_next)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] ahi,
                                              input logic [31:0] bhi);
        longint sa, sb, t, q, m;
        logic [63:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r  = 64'h0;
        case (op)
            4'd0:  r = {32'h0, a & b};
            4'd1:  r = {32'h0, a | b};
            4'd2:  begin t = sa + sb; r = {32'h0, t[31:0]}; end
            4'd3:  r = {32'h0, a ^ b};
            4'd4:  r = {32'h0, ~(a | b)};
            4'd5:  r = {32'h0, a << b[4:0]};
            4'd6:  begin t = sa - sb; r = {32'h0, t[31:0]}; end
            4'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd8:  r = {32'h0, a >> b[4:0]};
            4'd9:  begin t = sa >>> b[4:0]; r = {32'h0, t[31:0]}; end
            4'd10: begin t = sa * sb; r = t; end
            4'd11: r = {32'h0, a} * {32'h0, b};
            4'd12: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            4'd13: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            4'd14: r = {ahi, a} + {bhi, b};
            4'd15: r = (a < b) ? 64'd1 : 64'd0;
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    function automatic int unsigned word_of(input logic [31:0] addr);
        return (addr >> 2) % MEM_WORDS;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) model_mem[i] <= 32'h0;
        end else if (mem_write64) begin
            model_mem[word_of(mem_addr)]                   <= mem_wdata64[63:32];
            model_mem[(word_of(mem_addr) + 1) % MEM_WORDS] <= mem_wdata64[31:0];
        end else if (mem_write) begin
            model_mem[word_of(mem_addr)] <= mem_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t op=%0d a=%h b=%h addr=%h)",
                     name, act, exp, $time, alu_op, alu_a, alu_b, mem_addr);
        end
    endtask

    logic [63:0] e64;
    logic [31:0] e_sum, e_rd, e_rdn;
    int unsigned e_w;

    always @(negedge clk) begin
        if (check_en) begin
            e64   = model_alu(alu_op, alu_a, alu_b, alu_a_hi, alu_b_hi);
            e_sum = add_a + add_b;
            e_w   = word_of(mem_addr);
            e_rd  = mem_read ? model_mem[e_w] : 32'h0;
            e_rdn = mem_read ? model_mem[(e_w + 1) % MEM_WORDS] : 32'h0;
            check("alu_out64", alu_out64, e64);
            check("alu_out", {32'h0, alu_out}, {32'h0, e64[31:0]});
            check("zf", {63'h0, zf}, {63'h0, (e64[31:0] == 32'h0)});
            check("add_sum", {32'h0, add_sum}, {32'h0, e_sum});
            check("mem_rdata", {32'h0, mem_rdata}, {32'h0, e_rd});
            check("mem_rdata_next", {32'h0, mem_rdata_next}, {32'h0, e_rdn});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ahi, input logic [31:0] bhi);
        alu_op = op; alu_a = a; alu_b = b; alu_a_hi = ahi; alu_b_hi = bhi;
    endtask

    task automatic set_mem(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic wr64, input logic [31:0] wd, input logic [63:0] wd64);
        mem_addr = addr; mem_read = rd; mem_write = wr; mem_write64 = wr64;
        mem_wdata = wd; mem_wdata64 = wd64;
    endtask

    task automatic alu_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ahi, input logic [31:0] bhi,
                           input logic [63:0] exp64);
        set_alu(op, a, b, ahi, bhi);
        @(negedge clk);
        check(name, alu_out64, exp64);
        check({name, "_out"}, {32'h0, alu_out}, {32'h0, exp64[31:0]});
        check({name, "_zf"}, {63'h0, zf}, {63'h0, (exp64[31:0] == 32'h0)});
        next_cycle();
    endtask

    task automatic read_lit(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_rd, input logic [31:0] exp_rdn);
        set_mem(addr, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        check({name, "_rd"}, {32'h0, mem_rdata}, {32'h0, exp_rd});
        check({name, "_rdn"}, {32'h0, mem_rdata_next}, {32'h0, exp_rdn});
        next_cycle();
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] junk;
        int unsigned w;
        junk = $urandom();
        w    = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(248, 255);
        return (junk & 32'hFFFF_FC00) | (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        set_alu(4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        add_a = 32'h0; add_b = 32'h0;
        set_mem(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
        next_cycle();
        next_cycle();
        reset    = 1'b0;
        check_en = 1'b1;

        // Reset state: every address reads 0, and reads are gated by mem_read.
        read_lit("rst_0", 32'h0000_0000, 32'h0, 32'h0);
        read_lit("rst_3fc", 32'h0000_03FC, 32'h0, 32'h0);
        read_lit("rst_junk", 32'hFFFF_FF83, 32'h0, 32'h0);

        // ALU scenarios
        alu_lit("sub_eq", 4'd6, 32'd5, 32'd5, 32'h0, 32'h0, 64'h0);
        alu_lit("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 64'd1);
        alu_lit("sltu_big", 4'd15, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 64'd0);
        alu_lit("mult", 4'd10, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFA);
        alu_lit("multu", 4'd11, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 64'h0000_0002_FFFF_FFFA);
        alu_lit("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFD);
        alu_lit("divu_zero", 4'd13, 32'd9, 32'd0, 32'h0, 32'h0, 64'h0000_0009_FFFF_FFFF);
        alu_lit("div_zero", 4'd12, 32'hFFFF_FFF9, 32'd0, 32'h0, 32'h0, 64'hFFFF_FFF9_FFFF_FFFF);
        alu_lit("div_min", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'h0000_0000_8000_0000);
        alu_lit("add64", 4'd14, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 64'h0000_0002_0000_0000);
        alu_lit("sra", 4'd9, 32'h8000_0010, 32'hFFFF_FFE4, 32'h0, 32'h0, 64'h0000_0000_F800_0001);
        alu_lit("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0, 64'd1);

        add_a = 32'hFFFF_FFFC; add_b = 32'd8;
        @(negedge clk);
        check("adder_wrap", {32'h0, add_sum}, 64'd4);
        next_cycle();

        // Reset leaves the ALU and adder alone.
        reset = 1'b1;
        set_alu(4'd2, 32'd3, 32'd4, 32'h0, 32'h0);
        @(negedge clk);
        check("alu_in_reset", {32'h0, alu_out}, 64'd7);
        check("add_in_reset", {32'h0, add_sum}, 64'd4);
        next_cycle();
        reset = 1'b0;

        // Double-word write: old data during the write cycle, new data after.
        set_mem(32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0, 64'hAAAA_0000_5555_FFFF);
        @(negedge clk);
        check("w64_pre_rd", {32'h0, mem_rdata}, 64'h0);
        next_cycle();
        read_lit("w64_post", 32'h0000_0010, 32'hAAAA_0000, 32'h5555_FFFF);

        set_mem(32'h0000_0013, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 64'h0);
        next_cycle();
        read_lit("w32_post", 32'h0000_0010, 32'h1234_5678, 32'h5555_FFFF);

        // Both write strobes at the last word: double-word wins and wraps to 0.
        set_mem(32'h0000_03FC, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 64'h1111_2222_3333_4444);
        next_cycle();
        read_lit("wrap_hi", 32'h0000_03FC, 32'h1111_2222, 32'h3333_4444);
        read_lit("wrap_lo", 32'h0000_0000, 32'h3333_4444, 32'h0);

        // Reset beats a simultaneous write.
        reset = 1'b1;
        set_mem(32'h0000_0010, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 64'h0);
        next_cycle();
        reset = 1'b0;
        read_lit("post_rst_10", 32'h0000_0010, 32'h0, 32'h0);
        read_lit("post_rst_3fc", 32'h0000_03FC, 32'h0, 32'h0);
        read_lit("post_rst_0", 32'h0000_0000, 32'h0, 32'h0);

        // Random traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_alu(4'($urandom_range(0, 15)), rand_word(), rand_word(), rand_word(), rand_word());
            add_a = rand_word();
            add_b = rand_word();
            set_mem(rand_addr(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0), $urandom(), {$urandom(), $urandom()});
            next_cycle();
        end

        reset = 1'b0;
        set_mem(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0);
        next_cycle();
        next_cycle();
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
